// File: rtl/float_op.sv
// float_op: multi-cycle binary32 adder, sum = X + Y.
// Callers subtract by flipping bit 31 of Y before launching.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   launch request (rising edge detected internally)
//   X      in   32  operand A, binary32
//   Y      in   32  operand B, binary32
//   sum    out  32  registered result, held until the next result
//   valid  out  1   one-cycle pulse in the cycle sum is updated
//
// Optional build macro FLOAT_OP_ROUND_NEAREST_EN selects round-to-nearest-even
// in the ROUND state; without it the result is truncated. Latency is the same.
//
// state  | meaning
// IDLE   | waiting for a start rising edge; operands captured at launch
// UNPACK | split fields, flush denormals, detect NaN/Inf/zero specials
// ALIGN  | order operands by magnitude, shift smaller with guard/round/sticky
// ADD    | effective add or subtract of the aligned mantissas
// NORM   | carry-out right shift or leading-zero left shift
// ROUND  | round/truncate, range checks, write sum and pulse valid

module float_op (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [31:0] sum,
    output logic        valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_start_d;
    logic        w_launch;

    logic [31:0] r_x, r_y;
    logic        r_sx, r_sy;
    logic [7:0]  r_ex, r_ey;
    logic [23:0] r_mx, r_my;
    logic        r_spec;
    logic [31:0] r_spec_val;

    logic        r_sign, r_sub;
    logic [7:0]  r_exp;
    logic [26:0] r_ma, r_mb;
    logic [27:0] r_sumw;
    logic [26:0] r_nm;
    logic signed [9:0] r_nexp;
    logic        r_zero;
    logic [31:0] r_sum;
    logic        r_valid;

    // ---------------- FSM ----------------
    assign w_launch = (r_state == S_IDLE) && start && !r_start_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= start;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_launch) w_next = S_UNPACK;
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADD;
            S_ADD:    w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- UNPACK ----------------
    logic        w_xz, w_yz, w_xinf, w_yinf, w_xnan, w_ynan;
    logic        w_spec;
    logic [31:0] w_spec_val;

    always_comb begin
        w_xz   = (r_x[30:23] == 8'h00);
        w_yz   = (r_y[30:23] == 8'h00);
        w_xinf = (r_x[30:23] == 8'hFF) && (r_x[22:0] == 23'd0);
        w_yinf = (r_y[30:23] == 8'hFF) && (r_y[22:0] == 23'd0);
        w_xnan = (r_x[30:23] == 8'hFF) && (r_x[22:0] != 23'd0);
        w_ynan = (r_y[30:23] == 8'hFF) && (r_y[22:0] != 23'd0);
        w_spec     = 1'b1;
        w_spec_val = 32'h7FC0_0000;
        if (w_xnan || w_ynan || (w_xinf && w_yinf && (r_x[31] != r_y[31])))
            w_spec_val = 32'h7FC0_0000;
        else if (w_xinf)
            w_spec_val = {r_x[31], 8'hFF, 23'd0};
        else if (w_yinf)
            w_spec_val = {r_y[31], 8'hFF, 23'd0};
        else if (w_xz && w_yz)
            w_spec_val = {r_x[31] & r_y[31], 31'd0};
        else
            w_spec = 1'b0;
    end

    // ---------------- ALIGN ----------------
    logic        w_x_big;
    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb, w_diff;
    logic [23:0] w_ma, w_mb;
    logic [26:0] w_ext_b, w_shift_b, w_mask, w_al_b;

    always_comb begin
        w_x_big = ({r_ex, r_mx} >= {r_ey, r_my});
        w_sa = w_x_big ? r_sx : r_sy;
        w_sb = w_x_big ? r_sy : r_sx;
        w_ea = w_x_big ? r_ex : r_ey;
        w_eb = w_x_big ? r_ey : r_ex;
        w_ma = w_x_big ? r_mx : r_my;
        w_mb = w_x_big ? r_my : r_mx;
        w_diff    = w_ea - w_eb;
        w_ext_b   = {w_mb, 3'b000};
        w_shift_b = w_ext_b >> w_diff;
        w_mask    = (27'd1 << w_diff) - 27'd1;
        if (w_diff >= 8'd26)
            w_al_b = {26'd0, |w_mb};
        else
            w_al_b = {w_shift_b[26:1], w_shift_b[0] | (|(w_ext_b & w_mask))};
    end

    // ---------------- NORM ----------------
    logic [4:0]        w_lz;
    logic [26:0]       w_nm;
    logic signed [9:0] w_nexp;

    always_comb begin
        w_lz = 5'd0;
        // ascending scan: the highest set bit is the last one to win
        for (int i = 0; i < 27; i++) begin
            if (r_sumw[i]) w_lz = 5'(26 - i);
        end
        if (r_sumw[27]) begin
            w_nm   = {r_sumw[27:2], r_sumw[1] | r_sumw[0]};
            w_nexp = $signed({2'b00, r_exp}) + 10'sd1;
        end else begin
            w_nm   = r_sumw[26:0] << w_lz;
            w_nexp = $signed({2'b00, r_exp}) - $signed({5'b00000, w_lz});
        end
    end

    // ---------------- ROUND ----------------
    logic [24:0]       w_m25;
    logic signed [9:0] w_rexp;
    logic [22:0]       w_frac;
    logic [31:0]       w_result;

`ifdef FLOAT_OP_ROUND_NEAREST_EN
    logic w_inc;
    // ties go to even: round up on guard when round/sticky or lsb is set
    assign w_inc = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    assign w_m25 = {1'b0, r_nm[26:3]} + {24'd0, w_inc};
`else
    logic w_unused_grs;
    assign w_unused_grs = ^r_nm[2:0];
    assign w_m25 = {1'b0, r_nm[26:3]};
`endif

    always_comb begin
        w_rexp = r_nexp + $signed({9'd0, w_m25[24]});
        w_frac = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
        if (r_spec)
            w_result = r_spec_val;
        else if (r_zero)
            w_result = 32'h0000_0000;
        else if (w_rexp >= 10'sd255)
            w_result = {r_sign, 8'hFF, 23'd0};
        else if (w_rexp <= 10'sd0)
            w_result = {r_sign, 31'd0};
        else
            w_result = {r_sign, w_rexp[7:0], w_frac};
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= 32'd0;
            r_y        <= 32'd0;
            r_sx       <= 1'b0;
            r_sy       <= 1'b0;
            r_ex       <= 8'd0;
            r_ey       <= 8'd0;
            r_mx       <= 24'd0;
            r_my       <= 24'd0;
            r_spec     <= 1'b0;
            r_spec_val <= 32'd0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= 8'd0;
            r_ma       <= 27'd0;
            r_mb       <= 27'd0;
            r_sumw     <= 28'd0;
            r_nm       <= 27'd0;
            r_nexp     <= 10'sd0;
            r_zero     <= 1'b0;
            r_sum      <= 32'd0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_x <= X;
                        r_y <= Y;
                    end
                end
                S_UNPACK: begin
                    r_sx       <= r_x[31];
                    r_sy       <= r_y[31];
                    r_ex       <= r_x[30:23];
                    r_ey       <= r_y[30:23];
                    r_mx       <= w_xz ? 24'd0 : {1'b1, r_x[22:0]};
                    r_my       <= w_yz ? 24'd0 : {1'b1, r_y[22:0]};
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                end
                S_ALIGN: begin
                    r_sign <= w_sa;
                    r_sub  <= w_sa ^ w_sb;
                    r_exp  <= w_ea;
                    r_ma   <= {w_ma, 3'b000};
                    r_mb   <= w_al_b;
                end
                S_ADD: begin
                    r_sumw <= r_sub ? ({1'b0, r_ma} - {1'b0, r_mb})
                                    : ({1'b0, r_ma} + {1'b0, r_mb});
                end
                S_NORM: begin
                    r_nm   <= w_nm;
                    r_nexp <= w_nexp;
                    r_zero <= (r_sumw == 28'd0);
                end
                S_ROUND: begin
                    r_sum   <= w_result;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum   = r_sum;
    assign valid = r_valid;

endmodule

// File: tb/tb_float_op.sv
module tb_float_op;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] X, Y;
    logic [31:0] sum;
    logic        valid;

    float_op dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .sum   (sum),
        .valid (valid)
    );

    always #5 clk = ~clk;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int n_valid = 0;

    typedef struct {
        logic [31:0] exp;
        int          launch;
    } item_t;

    item_t q[$];
    item_t m_it;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: pops one expectation per valid pulse
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            n_valid++;
            if (q.size() == 0) begin
                chk("extra_valid", 32'd1, 32'd0);
            end else begin
                m_it = q.pop_front();
                chk("sum", sum, m_it.exp);
                chk("latency", 32'(cyc - m_it.launch), 32'd5);
            end
        end
    end

    // called at #1 after an edge with start low; launch edge is the next one
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        item_t it;
        X = a;
        Y = b;
        start = 1'b1;
        it.exp = e;
        it.launch = cyc + 1;
        q.push_back(it);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("timeout", 32'(q.size()), 32'd0);
    endtask

    localparam int NV = 13;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] ve [NV];

    initial begin
        int nv0;

        va[0]  = 32'h43e10ccd; vb[0]  = 32'h41433333;
        va[1]  = 32'h3d5d2f1b; vb[1]  = 32'h3c656042;
`ifdef FLOAT_OP_ROUND_NEAREST_EN
        ve[0]  = 32'h43E72667;
        ve[1]  = 32'h3D8B4396;
`else
        ve[0]  = 32'h43E72666;
        ve[1]  = 32'h3D8B4395;
`endif
        va[2]  = 32'h40000000; vb[2]  = 32'hBF800000; ve[2]  = 32'h3F800000;
        va[3]  = 32'h3F800000; vb[3]  = 32'hBF800000; ve[3]  = 32'h00000000;
        va[4]  = 32'h7F800000; vb[4]  = 32'hFF800000; ve[4]  = 32'h7FC00000;
        va[5]  = 32'h7F800000; vb[5]  = 32'h3F800000; ve[5]  = 32'h7F800000;
        va[6]  = 32'h7F7FFFFF; vb[6]  = 32'h7F7FFFFF; ve[6]  = 32'h7F800000;
        va[7]  = 32'h00000001; vb[7]  = 32'h3F800000; ve[7]  = 32'h3F800000;
        va[8]  = 32'h7FC00001; vb[8]  = 32'h3F800000; ve[8]  = 32'h7FC00000;
        va[9]  = 32'h80000000; vb[9]  = 32'h80000000; ve[9]  = 32'h80000000;
        va[10] = 32'h80000000; vb[10] = 32'h00000000; ve[10] = 32'h00000000;
        va[11] = 32'h40400000; vb[11] = 32'hFF800000; ve[11] = 32'hFF800000;
        va[12] = 32'hBF800000; vb[12] = 32'h40000000; ve[12] = 32'h3F800000;

        rst = 1'b1;
        start = 1'b0;
        X = 32'd0;
        Y = 32'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_sum", sum, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back vectors: each launch lands on the edge after the valid
        for (int i = 0; i < NV; i++) begin
            launch(va[i], vb[i], ve[i]);
            wait_done();
        end

        // start held high: exactly one pulse
        repeat (2) @(posedge clk);
        #1;
        nv0 = n_valid;
        launch(32'h40000000, 32'hBF800000, 32'h3F800000);
        start = 1'b1;
        repeat (10) @(posedge clk);
        #2 start = 1'b0;
        wait_done();
        repeat (8) @(posedge clk);
        #1;
        chk("hold_pulses", 32'(n_valid - nv0), 32'd1);

        // operand change and a fresh start edge while busy are both ignored
        nv0 = n_valid;
        launch(32'h43e10ccd, 32'h41433333, ve[0]);
        @(posedge clk);
        #1;
        X = 32'h3F800000;
        Y = 32'h3F800000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (8) @(posedge clk);
        #1;
        chk("busy_pulses", 32'(n_valid - nv0), 32'd1);

        // reset mid-operation: no pulse, sum cleared, next launch normal
        nv0 = n_valid;
        launch(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        #2;
        chk("abort_sum", sum, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pulses", 32'(n_valid - nv0), 32'd0);
        launch(32'h3d5d2f1b, 32'h3c656042, ve[1]);
        wait_done();

        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
